// File: rtl/lbg_vq_pkg.sv
// Shared constants, FSM state type and address helper
// for the LBG vector-quantiser codebook engines.
package lbg_vq_pkg;
  localparam int DATA_WIDTH = 14;
  localparam int DIM        = 13;
  localparam int NUM_CW     = 16;
  localparam int CW_AW      = 4;
  localparam int DIM_AW     = 4;
  localparam int ACC_WIDTH  = 34;
  localparam int SQ_WIDTH   = 2 * (DATA_WIDTH + 1) - 2;
  localparam int AW         = CW_AW + DIM_AW;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SEARCH,
    ST_DONE
  } state_e;

  function automatic logic [AW-1:0] cb_addr(
    input logic [CW_AW-1:0]  k,
    input logic [DIM_AW-1:0] d
  );
    return {k, d};
  endfunction
endpackage

// File: rtl/lbg_vq_search_if.sv
// Feature-in, codebook-read and result-out signals of the
// VQ nearest-codeword search engine.
interface lbg_vq_search_if;
  import lbg_vq_pkg::*;

  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [AW-1:0]                cb_rd_addr;
  logic signed [DATA_WIDTH-1:0] cb_rd_data;
  logic [CW_AW-1:0]             out_idx;
  logic [ACC_WIDTH-1:0]         out_dist;
  logic                         out_valid;
  logic                         out_ready;
  logic                         busy;

  modport slave (
    input  in_data, in_valid, cb_rd_data, out_ready,
    output in_ready, cb_rd_addr, out_idx, out_dist,
    output out_valid, busy
  );

  modport master (
    output in_data, in_valid, cb_rd_data, out_ready,
    input  in_ready, cb_rd_addr, out_idx, out_dist,
    input  out_valid, busy
  );
endinterface

// File: rtl/lbg_sqdiff.sv
// Combinational squared difference of two signed samples;
// shared with the LBG training datapath.
module lbg_sqdiff
  import lbg_vq_pkg::*;
(
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic [SQ_WIDTH-1:0]          sq_o
);
  logic signed [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH-1:0]      mag;

  assign diff = {a_i[DATA_WIDTH-1], a_i}
              - {b_i[DATA_WIDTH-1], b_i};

  // |diff| <= 2^14-1, so the magnitude fits DATA_WIDTH bits
  assign mag = diff[DATA_WIDTH] ? DATA_WIDTH'(-diff)
                                : diff[DATA_WIDTH-1:0];

  assign sq_o = SQ_WIDTH'(mag) * SQ_WIDTH'(mag);
endmodule

// File: rtl/lbg_vq_search.sv
// Nearest-codeword search: loads one feature vector, scans
// the codebook RAM and reports the closest index/distance.
module lbg_vq_search
  import lbg_vq_pkg::*;
(
  input logic            rd_clk,
  input logic            rd_rst,
  lbg_vq_search_if.slave bus
);
  localparam logic [DIM_AW-1:0] D_LAST = DIM_AW'(DIM - 1);
  localparam logic [CW_AW-1:0]  K_LAST = CW_AW'(NUM_CW - 1);

  state_e state_q, state_d;

  logic signed [DATA_WIDTH-1:0] x_q [DIM];
  logic [DIM_AW-1:0]    cnt_q;
  logic [CW_AW-1:0]     k_q, k1_q;
  logic [DIM_AW-1:0]    d_q, d1_q;
  logic                 issue_q, v1_q;
  logic [ACC_WIDTH-1:0] acc_q, best_dist_q, out_dist_q;
  logic [CW_AW-1:0]     best_idx_q, out_idx_q;
  logic [ACC_WIDTH-1:0] total;
  logic [SQ_WIDTH-1:0]  sq;
  logic in_hs, load_done, last_issue;
  logic last_cmp, final_cmp, better;

  assign bus.in_ready   = (state_q == ST_LOAD) && !rd_rst;
  assign bus.busy       = state_q != ST_LOAD;
  assign bus.out_valid  = state_q == ST_DONE;
  assign bus.out_idx    = out_idx_q;
  assign bus.out_dist   = out_dist_q;
  assign bus.cb_rd_addr = cb_addr(k_q, d_q);

  assign in_hs      = bus.in_valid && bus.in_ready;
  assign load_done  = in_hs && (cnt_q == D_LAST);
  assign last_issue = issue_q && (k_q == K_LAST)
                   && (d_q == D_LAST);
  assign last_cmp   = v1_q && (d1_q == D_LAST);
  assign final_cmp  = last_cmp && (k1_q == K_LAST);

  lbg_sqdiff u_sqdiff (
    .a_i  (x_q[d1_q]),
    .b_i  (bus.cb_rd_data),
    .sq_o (sq)
  );

  assign total  = (d1_q == '0 ? '0 : acc_q)
                + ACC_WIDTH'(sq);
  assign better = (k1_q == '0) || (total < best_dist_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD:   if (load_done)     state_d = ST_SEARCH;
      ST_SEARCH: if (final_cmp)     state_d = ST_DONE;
      ST_DONE:   if (bus.out_ready) state_d = ST_LOAD;
      default:                      state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      cnt_q      <= '0;
      k_q        <= '0;
      d_q        <= '0;
      issue_q    <= 1'b0;
      v1_q       <= 1'b0;
      out_idx_q  <= '0;
      out_dist_q <= '0;
    end else begin
      if (in_hs) cnt_q <= load_done ? '0 : cnt_q + 1'b1;
      if (load_done) begin
        k_q     <= '0;
        d_q     <= '0;
        issue_q <= 1'b1;
      end else if (issue_q) begin
        if (last_issue) begin
          issue_q <= 1'b0;
        end else if (d_q == D_LAST) begin
          d_q <= '0;
          k_q <= k_q + 1'b1;
        end else begin
          d_q <= d_q + 1'b1;
        end
      end
      v1_q <= issue_q;
      // Result registers only change once the full scan is in
      if (final_cmp) begin
        out_idx_q  <= better ? k1_q  : best_idx_q;
        out_dist_q <= better ? total : best_dist_q;
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (in_hs) x_q[cnt_q] <= bus.in_data;
    k1_q <= k_q;
    d1_q <= d_q;
    if (v1_q) acc_q <= total;
    if (last_cmp && better) begin
      best_idx_q  <= k1_q;
      best_dist_q <= total;
    end
  end
endmodule
